// File: rtl/alu_arbiter_pkg.sv
// Shared constants for the two-requester ALU arbiter: width default, opcodes, FSM states.
package alu_arbiter_pkg;

  localparam int unsigned DW_DEFAULT = 4;
  localparam int unsigned OP_W       = 4;

  localparam logic [OP_W-1:0] OP_ADD   = 4'd0;
  localparam logic [OP_W-1:0] OP_SUB   = 4'd1;
  localparam logic [OP_W-1:0] OP_NOTA  = 4'd2;
  localparam logic [OP_W-1:0] OP_AND   = 4'd3;
  localparam logic [OP_W-1:0] OP_OR    = 4'd4;
  localparam logic [OP_W-1:0] OP_NAND  = 4'd5;
  localparam logic [OP_W-1:0] OP_NOR   = 4'd6;
  localparam logic [OP_W-1:0] OP_XOR   = 4'd7;
  localparam logic [OP_W-1:0] OP_XNOR  = 4'd8;
  localparam logic [OP_W-1:0] OP_PASSA = 4'd9;
  localparam logic [OP_W-1:0] OP_ZERO  = 4'd10;
  localparam logic [OP_W-1:0] OP_ONE   = 4'd11;
  localparam logic [OP_W-1:0] OP_INCA  = 4'd12;
  localparam logic [OP_W-1:0] OP_DECA  = 4'd13;
  localparam logic [OP_W-1:0] OP_INCB  = 4'd14;
  localparam logic [OP_W-1:0] OP_DECB  = 4'd15;

  typedef enum logic {
    IDLE = 1'b0,
    EXEC = 1'b1
  } state_t;

  // Round-robin pick: on a tie the requester that did not win last time goes next.
  function automatic logic rr_pick(input logic r0, input logic r1, input logic last_id);
    logic id;
    if (r0 && r1) id = ~last_id;
    else          id = r1;
    return id;
  endfunction

endpackage

// File: rtl/alu_arbiter_core.sv
// Purely combinational ALU; all arithmetic wraps modulo 2^DW.
module alu_core
  import alu_arbiter_pkg::*;
#(
  parameter int unsigned DW = DW_DEFAULT
) (
  input  logic [OP_W-1:0] op,
  input  logic [DW-1:0]   a,
  input  logic [DW-1:0]   b,
  output logic [DW-1:0]   res_c
);

  localparam logic [DW-1:0] ONE = DW'(1);

  // Opcode decode; carries and borrows fall off the top bit.
  always_comb begin
    res_c = '0;
    case (op)
      OP_ADD:   res_c = a + b;
      OP_SUB:   res_c = a - b;
      OP_NOTA:  res_c = ~a;
      OP_AND:   res_c = a & b;
      OP_OR:    res_c = a | b;
      OP_NAND:  res_c = ~(a & b);
      OP_NOR:   res_c = ~(a | b);
      OP_XOR:   res_c = a ^ b;
      OP_XNOR:  res_c = ~(a ^ b);
      OP_PASSA: res_c = a;
      OP_ZERO:  res_c = '0;
      OP_ONE:   res_c = ONE;
      OP_INCA:  res_c = a + ONE;
      OP_DECA:  res_c = a - ONE;
      OP_INCB:  res_c = b + ONE;
      OP_DECB:  res_c = b - ONE;
      default:  res_c = '0;
    endcase
  end

endmodule

// File: rtl/alu_arbiter.sv
// Two-requester round-robin front end to a shared ALU: grant, latch operands, compute, report.
module alu_arbiter
  import alu_arbiter_pkg::*;
#(
  parameter int unsigned DW = DW_DEFAULT
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            req0,
  input  logic [3:0]      op0,
  input  logic [DW-1:0]   a0,
  input  logic [DW-1:0]   b0,
  output logic            ack0,
  input  logic            req1,
  input  logic [3:0]      op1,
  input  logic [DW-1:0]   a1,
  input  logic [DW-1:0]   b1,
  output logic            ack1,
  output logic [DW-1:0]   y,
  output logic            y_valid,
  output logic            y_id,
  output logic            y_zero,
  output logic            busy
);

  state_t            state;
  state_t            state_d;
  logic              accept;
  logic              grant_id;
  logic              last_id;
  logic              id_q;
  logic [OP_W-1:0]   op_q;
  logic [DW-1:0]     a_q;
  logic [DW-1:0]     b_q;
  logic [DW-1:0]     alu_res_c;

  alu_core #(.DW(DW)) u_alu (
    .op    (op_q),
    .a     (a_q),
    .b     (b_q),
    .res_c (alu_res_c)
  );

  // State register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_d;
  end

  // Next state and grant decision; requests are only looked at in IDLE.
  always_comb begin
    state_d  = state;
    accept   = 1'b0;
    grant_id = 1'b0;
    case (state)
      IDLE: begin
        if (req0 || req1) begin
          accept   = 1'b1;
          grant_id = rr_pick(req0, req1, last_id);
          state_d  = EXEC;
        end
      end
      EXEC:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Operand capture and ack pulse on the accepting edge.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      op_q <= '0;
      a_q  <= '0;
      b_q  <= '0;
      id_q <= 1'b0;
      ack0 <= 1'b0;
      ack1 <= 1'b0;
    end else begin
      ack0 <= accept && !grant_id;
      ack1 <= accept && grant_id;
      if (accept) begin
        id_q <= grant_id;
        if (grant_id) begin
          op_q <= op1;
          a_q  <= a1;
          b_q  <= b1;
        end else begin
          op_q <= op0;
          a_q  <= a0;
          b_q  <= b0;
        end
      end
    end
  end

  // Result registers; y/y_id/y_zero hold until the next completion.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      y       <= '0;
      y_valid <= 1'b0;
      y_id    <= 1'b0;
      y_zero  <= 1'b1;
      last_id <= 1'b1;
    end else begin
      y_valid <= 1'b0;
      if (state == EXEC) begin
        y       <= alu_res_c;
        y_zero  <= (alu_res_c == '0);
        y_id    <= id_q;
        last_id <= id_q;
        y_valid <= 1'b1;
      end
    end
  end

  // Busy mirrors the registered state.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) busy <= 1'b0;
    else     busy <= (state_d != IDLE);
  end

endmodule

// File: tb/tb_alu_arbiter.sv
// Self-checking bench for alu_arbiter: directed scenarios plus randomized traffic vs. a transaction model.
module tb_alu_arbiter;

  localparam int unsigned DW = 4;

  logic          clk = 1'b0;
  logic          rst;
  logic          req0, req1;
  logic [3:0]    op0, op1;
  logic [DW-1:0] a0, b0, a1, b1;
  logic          ack0, ack1;
  logic [DW-1:0] y;
  logic          y_valid, y_id, y_zero, busy;

  int checks = 0;
  int errors = 0;
  bit last = 1'b1;

  alu_arbiter #(.DW(DW)) dut (
    .clk(clk), .rst(rst),
    .req0(req0), .op0(op0), .a0(a0), .b0(b0), .ack0(ack0),
    .req1(req1), .op1(op1), .a1(a1), .b1(b1), .ack1(ack1),
    .y(y), .y_valid(y_valid), .y_id(y_id), .y_zero(y_zero), .busy(busy)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Reference ALU written straight from the opcode table with integer arithmetic.
  function automatic int ref_alu(input int op, input int a, input int b);
    int r;
    case (op)
      0: r = a + b;       1: r = a - b;       2: r = ~a;          3: r = a & b;
      4: r = a | b;       5: r = ~(a & b);    6: r = ~(a | b);    7: r = a ^ b;
      8: r = ~(a ^ b);    9: r = a;           10: r = 0;          11: r = 1;
      12: r = a + 1;      13: r = a - 1;      14: r = b + 1;      default: r = b - 1;
    endcase
    return r & ((1 << DW) - 1);
  endfunction

  // One full transaction from IDLE with the current request lines; exp_lit >= 0 overrides the model result.
  task automatic step_op(input string tag, input bit drop, input int exp_lit);
    bit id;
    int ey;
    if (req0 && req1) id = ~last;
    else              id = req1;
    ey = id ? ref_alu(int'(op1), int'(a1), int'(b1)) : ref_alu(int'(op0), int'(a0), int'(b0));
    if (exp_lit >= 0) ey = exp_lit;
    tick();
    chk({tag, ".ack0"}, 32'(ack0), 32'(!id));
    chk({tag, ".ack1"}, 32'(ack1), 32'(id));
    chk({tag, ".vld_lo"}, 32'(y_valid), 0);
    chk({tag, ".busy_hi"}, 32'(busy), 1);
    if (drop) begin
      if (id) req1 = 1'b0;
      else    req0 = 1'b0;
    end
    tick();
    chk({tag, ".vld_hi"}, 32'(y_valid), 1);
    chk({tag, ".y"}, 32'(y), 32'(ey));
    chk({tag, ".y_id"}, 32'(y_id), 32'(id));
    chk({tag, ".y_zero"}, 32'(y_zero), 32'(ey == 0));
    chk({tag, ".acks_lo"}, 32'({ack0, ack1}), 0);
    chk({tag, ".busy_lo"}, 32'(busy), 0);
    last = id;
  endtask

  task automatic check_reset_vals(input string tag);
    chk({tag, ".y"}, 32'(y), 0);
    chk({tag, ".y_valid"}, 32'(y_valid), 0);
    chk({tag, ".y_id"}, 32'(y_id), 0);
    chk({tag, ".y_zero"}, 32'(y_zero), 1);
    chk({tag, ".acks"}, 32'({ack0, ack1}), 0);
    chk({tag, ".busy"}, 32'(busy), 0);
  endtask

  initial begin
    int sweep [16] = '{4'hB, 4'h3, 4'h8, 4'h4, 4'h7, 4'hB, 4'h8, 4'h3,
                       4'hC, 4'h7, 4'h0, 4'h1, 4'h8, 4'h6, 4'h5, 4'h3};
    logic [DW-1:0] y_hold;
    rst = 1'b1;
    req0 = 0; req1 = 0; op0 = 0; op1 = 0; a0 = 0; b0 = 0; a1 = 0; b1 = 0;
    tick();
    check_reset_vals("reset");
    rst = 1'b0;
    tick();
    chk("idle.busy", 32'(busy), 0);

    // Single add.
    req0 = 1; op0 = 4'd0; a0 = 4'd7; b0 = 4'd4;
    step_op("add", 1'b1, 4'hB);

    // Outputs hold between completions.
    y_hold = y;
    tick();
    chk("hold.y", 32'(y), 32'(y_hold));
    chk("hold.vld", 32'(y_valid), 0);
    chk("hold.y_id", 32'(y_id), 0);

    // Tie with both held: grants alternate starting from the requester not last served.
    req0 = 1; op0 = 4'd3; a0 = 4'd7; b0 = 4'd4;
    req1 = 1; op1 = 4'd7; a1 = 4'd7; b1 = 4'd4;
    step_op("tie1", 1'b0, (last == 1'b0) ? 4'h3 : 4'h4);
    step_op("tie2", 1'b0, (last == 1'b0) ? 4'h3 : 4'h4);
    step_op("tie3", 1'b0, (last == 1'b0) ? 4'h3 : 4'h4);
    step_op("tie4", 1'b0, (last == 1'b0) ? 4'h3 : 4'h4);
    req0 = 0; req1 = 0;

    // Wrap-around cases.
    req1 = 1; op1 = 4'd1;  a1 = 4'd4;  b1 = 4'd7; step_op("wrap_sub", 1'b1, 4'hD);
    req1 = 1; op1 = 4'd12; a1 = 4'hF;  b1 = 4'd0; step_op("wrap_inc", 1'b1, 4'h0);
    req0 = 1; op0 = 4'd15; a0 = 4'd3;  b0 = 4'd0; step_op("wrap_decb", 1'b1, 4'hF);

    // Opcode sweep on requester 0.
    for (int i = 0; i < 16; i++) begin
      req0 = 1; op0 = 4'(i); a0 = 4'd7; b0 = 4'd4;
      step_op($sformatf("sweep%0d", i), 1'b1, sweep[i]);
    end

    // Reset during EXEC discards the operation.
    req0 = 1; op0 = 4'd0; a0 = 4'd1; b0 = 4'd1;
    tick();
    chk("rstmid.ack0", 32'(ack0), 1);
    req0 = 0;
    #2 rst = 1'b1;
    #1 check_reset_vals("rstmid.async");
    tick();
    rst = 1'b0;
    last = 1'b1;
    chk("rstmid.novld", 32'(y_valid), 0);
    tick();
    chk("rstmid.novld2", 32'(y_valid), 0);
    chk("rstmid.y", 32'(y), 0);
    req0 = 1; req1 = 1; op0 = 4'd9; a0 = 4'd5; op1 = 4'd11;
    step_op("after_rst", 1'b0, 4'h5);
    req0 = 0; req1 = 0;
    tick();

    // Late request arriving during EXEC waits for IDLE.
    req0 = 1; op0 = 4'd7; a0 = 4'd6; b0 = 4'd3;
    tick();
    chk("late.ack0", 32'(ack0), 1);
    req0 = 0;
    req1 = 1; op1 = 4'd14; a1 = 4'd0; b1 = 4'd9;
    tick();
    chk("late.vld", 32'(y_valid), 1);
    chk("late.y", 32'(y), 32'(ref_alu(7, 6, 3)));
    chk("late.ack1_wait", 32'(ack1), 0);
    tick();
    chk("late.ack1", 32'(ack1), 1);
    chk("late.vld_lo", 32'(y_valid), 0);
    req1 = 0;
    tick();
    chk("late.vld2", 32'(y_valid), 1);
    chk("late.y2", 32'(y), 4'hA);
    chk("late.id2", 32'(y_id), 1);
    last = 1'b1;

    // Randomized traffic.
    for (int i = 0; i < 60; i++) begin
      int r;
      r = $urandom_range(0, 3);
      req0 = r[0]; req1 = r[1];
      op0 = 4'($urandom); a0 = 4'($urandom); b0 = 4'($urandom);
      op1 = 4'($urandom); a1 = 4'($urandom); b1 = 4'($urandom);
      if (!req0 && !req1) begin
        y_hold = y;
        tick();
        chk("rnd.idle_ack", 32'({ack0, ack1}), 0);
        chk("rnd.idle_busy", 32'(busy), 0);
        chk("rnd.idle_hold", 32'(y), 32'(y_hold));
      end else begin
        step_op($sformatf("rnd%0d", i), 1'($urandom_range(0, 1)), -1);
      end
    end
    req0 = 0; req1 = 0;
    tick();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/alu_arbiter.md
ALU_ARBITER -- requirements
Module: alu_arbiter

Interface
REQ-001 Parameter: DW, default 4, operand and result width in bits.
REQ-002 clk  input  1  single clock, all state updates on rising edge.
REQ-003 rst  input  1  reset, asynchronous, active-high.
REQ-004 req0  input  1  requester 0 operation request, held high until ack0.
REQ-005 op0  input  4  requester 0 opcode.
REQ-006 a0, b0  input  DW each  requester 0 operands.
REQ-007 ack0  output  1  one-cycle pulse: requester 0 operands captured.
REQ-008 req1, op1, a1, b1, ack1: same as REQ-004..REQ-007, for requester 1.
REQ-009 y  output  DW  registered ALU result.
REQ-010 y_valid  output  1  one-cycle pulse: y, y_id and y_zero are valid.
REQ-011 y_id  output  1  requester that owns the current result (0 or 1).
REQ-012 y_zero  output  1  high when y equals 0.
REQ-013 busy  output  1  high whenever the state is not IDLE.

Function
REQ-014 The FSM SHALL have two states:
- IDLE: accepts a request.
- EXEC: computes and registers the result.
REQ-015 In IDLE, on an edge where req0 or req1 is high, the block SHALL:
- select one requester (REQ-016);
- latch that requester's op, a and b;
- pulse that requester's ack for exactly one cycle;
- enter EXEC.
REQ-016 Arbitration SHALL be round-robin:
- last_id records the last granted requester; reset value 1, so requester 0 wins the first tie;
- when both requests are high, the requester not equal to last_id wins;
- when only one request is high, that requester wins regardless of last_id.
REQ-017 In EXEC, on the next edge, the block SHALL:
- load y with the ALU result of the latched operands;
- pulse y_valid;
- set y_id to the granted requester and update last_id to it;
- return to IDLE.
REQ-018 Timing:
- latency from the accepting edge to y_valid high is exactly 2 edges;
- throughput is at most one operation every 2 cycles;
- requests are ignored while in EXEC.
REQ-019 ALU opcodes SHALL be, with all arithmetic modulo 2^DW and the result truncated to DW bits:
- 0: a+b; 1: a-b; 2: ~a; 3: a&b; 4: a|b; 5: ~(a&b); 6: ~(a|b); 7: a^b;
- 8: ~(a^b); 9: a; 10: 0; 11: 1;
- 12: a+1; 13: a-1; 14: b+1; 15: b-1.
REQ-020 Carry and borrow SHALL be discarded; for example, 4'hF+1 gives 0 and 0-1 gives 4'hF.
REQ-021 y, y_id and y_zero SHALL hold their values between y_valid pulses.
REQ-022 Each of ack0, ack1 and y_valid SHALL be high for exactly one cycle per operation.
REQ-023 ack0 and ack1 SHALL never be high in the same cycle.
REQ-024 An ack SHALL never coincide with y_valid, because ack is issued in IDLE and y_valid on leaving EXEC.
REQ-025 A requester that still has req high in the cycle after its ack SHALL be treated as issuing a new request.

Reset
REQ-026 When rst is asserted, the block SHALL immediately set:
- state to IDLE;
- y=0, y_valid=0, y_id=0, y_zero=1;
- ack0=0, ack1=0, busy=0;
- last_id=1;
- the latched op and operands to 0.
REQ-027 If reset is asserted during EXEC, the in-flight operation SHALL be discarded with no y_valid pulse.
REQ-028 After reset deasserts, operation SHALL resume from IDLE on the first rising edge.

Structure
REQ-029 A shared package SHALL hold:
- opcode constants (OP_ADD .. OP_DECB);
- the state encoding (IDLE, EXEC);
- the default value of DW.
REQ-030 The ALU SHALL be one purely combinational sub-module, alu_core, implementing REQ-019.
REQ-031 The arbiter, operand registers and FSM SHALL reside in alu_arbiter.

Verification
REQ-032 Single add: req0 with op0=0, a0=7, b0=4 -> ack0 after edge 1; y_valid after edge 2 with y=4'hB, y_id=0, y_zero=0.
REQ-033 Tie, round-robin: req0 and req1 held continuously, with op0=3 (a0=7, b0=4) and op1=7 (a1=7, b1=4):
- grants alternate 0,1,0,1 starting with 0;
- results alternate 4'h4 and 4'h3.
REQ-034 Wrap-around: op=1 with a=4, b=7 -> y=4'hD; op=12 with a=4'hF -> y=0 and y_zero=1; op=15 with b=0 -> y=4'hF.
REQ-035 Opcode sweep: a=7, b=4 with op 0..15 -> y = B,3,8,4,7,B,8,3,C,7,0,1,8,6,5,3.
REQ-036 Reset mid-operation: assert rst during EXEC -> no y_valid pulse; all outputs at REQ-026 values; the next request is served normally.
REQ-037 Late request: req1 rises while in EXEC -> not acked until the following IDLE cycle; no ack overlaps y_valid.
